// File: rtl/alu_result_register.sv
// alu_result_register
//   Result register stage behind the Lab4 ALU. A debounced press of the
//   active-low pushbutton captures ALUOut into Q and pushes it onto a
//   DEPTH-entry history buffer. Q feeds back as the ALU's B operand.
//
// Ports
//   Clock         in   system clock, all state on rising edge
//   Reset         in   asynchronous, active-high
//   KeyN          in   raw pushbutton, active-low, asynchronous to Clock
//   ALUOut        in   ALU result, sampled on the capture edge
//   HistSel       in   history index, 0 = newest
//   Q             out  last captured result
//   HistOut       out  hist[HistSel] when that entry is valid, else 0
//   Count         out  number of valid history entries, saturates at DEPTH
//   CapturePulse  out  one-cycle pulse per accepted press
//
// Debounce FSM
//   state        | meaning
//   IDLE         | key released and stable, waiting for a press
//   PRESS_WAIT   | key seen low, counting stable-low cycles
//   HELD         | press accepted and captured, waiting for release
//   RELEASE_WAIT | key seen high, counting stable-high cycles

module alu_result_register #(
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       KeyN,
    input  logic [DATA_W-1:0]          ALUOut,
    input  logic [$clog2(DEPTH)-1:0]   HistSel,
    output logic [DATA_W-1:0]          Q,
    output logic [DATA_W-1:0]          HistOut,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       CapturePulse
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               key_s;
    logic               capture;

    logic [DATA_W-1:0]  hist_q [DEPTH];
    logic [DATA_W-1:0]  q_q;
    logic [COUNT_W-1:0] count_q;
    logic               pulse_q;

    // Two-flop synchroniser; resets to the released level so a key held
    // through reset still has to pass a full debounce.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], KeyN};
        end
    end

    assign key_s = sync_q[1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture datapath. ALUOut may be a function of Q; the register samples
    // the pre-edge value, so there is no combinational loop through Q.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q     <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            pulse_q <= capture;
            if (capture) begin
                q_q       <= ALUOut;
                hist_q[0] <= ALUOut;
                for (int i = DEPTH - 1; i > 0; i--) begin
                    hist_q[i] <= hist_q[i-1];
                end
                if (count_q != COUNT_MAX) begin
                    count_q <= count_q + COUNT_W'(1);
                end
            end
        end
    end

    assign Q            = q_q;
    assign Count        = count_q;
    assign CapturePulse = pulse_q;

    // Entries beyond Count were never written since reset; mask them.
    assign HistOut = ({1'b0, HistSel} < count_q) ? hist_q[HistSel] : '0;

endmodule
